tetromino_cell_painter: RTL and testbench

Consumer of the game-logic block's falling-piece outputs. Once per frame, captures the four previous and four current cell coordinates plus the piece colour. It then streams pixel writes into the board framebuffer: first erasing the previous cells to background, then painting the current cells in the piece colour. It sits between the game-logic block and the framebuffer write port, in the `Clk` domain.

---
 rtl/tetromino_cell_painter.sv | 256 +++++++++++++++++++++++++
 tb/tb_tetromino_cell_painter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tetromino_cell_painter.sv
// Purpose: once per frame, erase the falling piece's previous cells and paint its current cells into the framebuffer.
// Latency: capture on the 4th Clk edge after frame_clk rises, first fb_we the cycle after, CELL_PX*CELL_PX cycles per painted cell.
// Backpressure: fb_we/fb_addr/fb_data hold until fb_ready; one frame edge may queue behind a pass, a further one sets overrun.
//
// Ports:
//   Clk, Reset (asynchronous, active-low)     - single clock domain
//   frame_clk                                 - frame strobe, asynchronous to Clk
//   blockXPos/blockYPos[4]                    - current piece cells
//   blockXPrev/blockYPrev[4]                  - previous piece cells
//   blockColor                                - piece colour
//   fb_ready, fb_we, fb_addr, fb_data         - framebuffer write port
//   busy                                      - high in ERASE, DRAW and DONE
//   overrun                                   - sticky, a frame edge arrived while one was already pending
// Optional feature: define PAINTER_SKIP_OVERLAP_EN to leave previous cells that are also current cells un-erased.
module tetromino_cell_painter #(
    parameter int          BOARD_COLS = 10,
    parameter int          BOARD_ROWS = 20,
    parameter int          CELL_PX    = 16,
    parameter int          FB_WIDTH   = 160,
    parameter logic [15:0] BG_COLOR   = 16'h0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [6:0]  blockXPos  [4],
    input  logic [6:0]  blockYPos  [4],
    input  logic [6:0]  blockXPrev [4],
    input  logic [6:0]  blockYPrev [4],
    input  logic [15:0] blockColor,
    input  logic        fb_ready,
    output logic        fb_we,
    output logic [15:0] fb_addr,
    output logic [15:0] fb_data,
    output logic        busy,
    output logic        overrun
);

    localparam int            CW      = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
    localparam logic [CW-1:0] PX_LAST = CW'(CELL_PX - 1);
    localparam logic [CW-1:0] PX_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Cells are handled as eight slots: 0..3 are previous cells (erase),
    // 4..7 are current cells (draw). Slot value 8 means "no more slots".
    function automatic logic in_board(input logic [6:0] x, input logic [6:0] y);
        return (x < 7'(BOARD_COLS)) && (y < 7'(BOARD_ROWS));
    endfunction

    // Lowest slot index >= from whose mask bit is set, or 8 if none.
    function automatic logic [3:0] next_slot(input logic [7:0] mask, input logic [3:0] from);
        logic [3:0] res;
        res = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (4'(i) >= from)) begin
                res = 4'(i);
            end
        end
        return res;
    endfunction

    function automatic state_e slot_state(input logic [3:0] slot);
        state_e st;
        if (slot < 4'd4) begin
            st = ERASE;
        end else if (slot < 4'd8) begin
            st = DRAW;
        end else begin
            st = DONE;
        end
        return st;
    endfunction

    // Frame strobe synchroniser and edge detector
    logic sync1_q, sync2_q, sync3_q;
    logic pending_q, pending_d;
    logic overrun_q, overrun_d;
    logic frame_edge;

    // Pass control
    state_e         state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [CW-1:0]  r_q, r_d;
    logic [CW-1:0]  c_q, c_d;
    logic [7:0]     valid_q, valid_d;
    logic           capture;
    logic           writing;
    logic           wr_done;

    // Shadow copies of the game-logic outputs, loaded at capture
    logic [6:0]     xpos_q  [4];
    logic [6:0]     ypos_q  [4];
    logic [6:0]     xprev_q [4];
    logic [6:0]     yprev_q [4];
    logic [15:0]    color_q;

    logic [7:0]     mask_in;
    logic [3:0]     first_slot;
    logic [3:0]     after_slot;

    logic [6:0]     cur_x, cur_y;
    logic [15:0]    row_px, col_px, pix_addr;

    assign frame_edge = sync2_q & ~sync3_q;
    assign capture    = (state_q == IDLE) && pending_q;
    assign writing    = (state_q == ERASE) || (state_q == DRAW);
    assign wr_done    = writing && fb_ready;

    // Which of the eight slots produce writes, judged on the live inputs so
    // the very first slot can be chosen in the capture cycle itself.
    always_comb begin
        mask_in = '0;
        for (int i = 0; i < 4; i++) begin
            mask_in[i]     = in_board(blockXPrev[i], blockYPrev[i]);
            mask_in[4 + i] = in_board(blockXPos[i], blockYPos[i]);
`ifdef PAINTER_SKIP_OVERLAP_EN
            // The draw phase repaints this cell anyway, so erasing it would only flicker.
            for (int j = 0; j < 4; j++) begin
                if ((blockXPrev[i] == blockXPos[j]) && (blockYPrev[i] == blockYPos[j])) begin
                    mask_in[i] = 1'b0;
                end
            end
`endif
        end
    end

    assign first_slot = next_slot(mask_in, 4'd0);
    assign after_slot = next_slot(valid_q, {1'b0, idx_q} + 4'd1);

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        r_d       = r_q;
        c_d       = c_q;
        valid_d   = valid_q;
        pending_d = pending_q;
        overrun_d = overrun_q;

        // An edge in the capture cycle re-arms pending rather than overrunning.
        if (frame_edge) begin
            pending_d = 1'b1;
            if (pending_q && !capture) begin
                overrun_d = 1'b1;
            end
        end else if (capture) begin
            pending_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (capture) begin
                    valid_d = mask_in;
                    idx_d   = first_slot[2:0];
                    r_d     = '0;
                    c_d     = '0;
                    state_d = slot_state(first_slot);
                end
            end
            ERASE, DRAW: begin
                if (wr_done) begin
                    if (c_q == PX_LAST) begin
                        c_d = '0;
                        if (r_q == PX_LAST) begin
                            // Last pixel of the cell: jump straight to the next
                            // live slot so skipped cells cost no cycles.
                            r_d     = '0;
                            idx_d   = after_slot[2:0];
                            state_d = slot_state(after_slot);
                        end else begin
                            r_d = r_q + PX_ONE;
                        end
                    end else begin
                        c_d = c_q + PX_ONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and control registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            state_q   <= IDLE;
            idx_q     <= '0;
            r_q       <= '0;
            c_q       <= '0;
            valid_q   <= '0;
        end else begin
            sync1_q   <= frame_clk;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
            r_q       <= r_d;
            c_q       <= c_d;
            valid_q   <= valid_d;
        end
    end

    // Shadow registers: inputs are ignored outside the capture cycle
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 4; i++) begin
                xpos_q[i]  <= '0;
                ypos_q[i]  <= '0;
                xprev_q[i] <= '0;
                yprev_q[i] <= '0;
            end
            color_q <= '0;
        end else if (capture) begin
            for (int i = 0; i < 4; i++) begin
                xpos_q[i]  <= blockXPos[i];
                ypos_q[i]  <= blockYPos[i];
                xprev_q[i] <= blockXPrev[i];
                yprev_q[i] <= blockYPrev[i];
            end
            color_q <= blockColor;
        end
    end

    // Pixel address of the current slot; all registers feeding it are frozen
    // while a write is stalled, so address and data hold without extra staging.
    assign cur_x    = idx_q[2] ? xpos_q[idx_q[1:0]] : xprev_q[idx_q[1:0]];
    assign cur_y    = idx_q[2] ? ypos_q[idx_q[1:0]] : yprev_q[idx_q[1:0]];
    assign row_px   = 16'(cur_y) * 16'(CELL_PX) + 16'(r_q);
    assign col_px   = 16'(cur_x) * 16'(CELL_PX) + 16'(c_q);
    assign pix_addr = row_px * 16'(FB_WIDTH) + col_px;

    // Outputs decode from the asynchronously reset state, so asserting Reset
    // drops fb_we at once and no write can complete afterwards.
    assign fb_we   = writing;
    assign fb_addr = writing ? pix_addr : 16'h0000;
    assign fb_data = writing ? (idx_q[2] ? color_q : BG_COLOR) : 16'h0000;
    assign busy    = (state_q != IDLE);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_tetromino_cell_painter.sv
module tb_tetromino_cell_painter;

`ifdef PAINTER_SKIP_OVERLAP_EN
    localparam int NE_MAIN = 512;
`else
    localparam int NE_MAIN = 1024;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic [6:0]  px_cur  [4];
    logic [6:0]  py_cur  [4];
    logic [6:0]  px_prev [4];
    logic [6:0]  py_prev [4];
    logic [15:0] color;
    logic        fb_ready;
    logic        fb_we;
    logic [15:0] fb_addr;
    logic [15:0] fb_data;
    logic        busy;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] got_a[$], got_d[$];
    logic [15:0] exp_a[$], exp_d[$];
    logic [15:0] ref_a[$], ref_d[$];

    always #5 Clk = ~Clk;

    tetromino_cell_painter dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .blockXPos  (px_cur),
        .blockYPos  (py_cur),
        .blockXPrev (px_prev),
        .blockYPrev (py_prev),
        .blockColor (color),
        .fb_ready   (fb_ready),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .busy       (busy),
        .overrun    (overrun)
    );

    function automatic logic [15:0] ref_addr(input int x, input int y, input int r, input int c);
        return 16'((y * 16 + r) * 160 + x * 16 + c);
    endfunction

    task automatic set_stim(input int sel);
        if (sel == 0) begin
            px_prev[0] = 7'd4; py_prev[0] = 7'd0; px_prev[1] = 7'd4; py_prev[1] = 7'd1;
            px_prev[2] = 7'd5; py_prev[2] = 7'd1; px_prev[3] = 7'd5; py_prev[3] = 7'd2;
            px_cur[0]  = 7'd4; py_cur[0]  = 7'd1; px_cur[1]  = 7'd4; py_cur[1]  = 7'd2;
            px_cur[2]  = 7'd5; py_cur[2]  = 7'd2; px_cur[3]  = 7'd5; py_cur[3]  = 7'd3;
            color = 16'h0F00;
        end else begin
            for (int i = 0; i < 4; i++) begin
                px_prev[i] = 7'd0; py_prev[i] = 7'd0;
            end
            px_cur[0] = 7'd12; py_cur[0] = 7'd5; px_cur[1] = 7'd0; py_cur[1] = 7'd1;
            px_cur[2] = 7'd1;  py_cur[2] = 7'd1; px_cur[3] = 7'd2; py_cur[3] = 7'd1;
            color = 16'hABCD;
        end
    endtask

    // Reference write list for the current stimulus
    task automatic build_expected();
        bit skip;
        exp_a.delete(); exp_d.delete();
        for (int k = 0; k < 4; k++) begin
            skip = (px_prev[k] >= 7'd10) || (py_prev[k] >= 7'd20);
`ifdef PAINTER_SKIP_OVERLAP_EN
            for (int j = 0; j < 4; j++)
                if (px_prev[k] == px_cur[j] && py_prev[k] == py_cur[j]) skip = 1'b1;
`endif
            if (!skip)
                for (int r = 0; r < 16; r++)
                    for (int c = 0; c < 16; c++) begin
                        exp_a.push_back(ref_addr(int'(px_prev[k]), int'(py_prev[k]), r, c));
                        exp_d.push_back(16'h0000);
                    end
        end
        for (int k = 0; k < 4; k++) begin
            if (px_cur[k] < 7'd10 && py_cur[k] < 7'd20)
                for (int r = 0; r < 16; r++)
                    for (int c = 0; c < 16; c++) begin
                        exp_a.push_back(ref_addr(int'(px_cur[k]), int'(py_cur[k]), r, c));
                        exp_d.push_back(color);
                    end
        end
    endtask

    task automatic frame_rise();
        @(posedge Clk); #1 frame_clk = 1'b1;
        repeat (3) @(posedge Clk);
        #1 frame_clk = 1'b0;
    endtask

    // Drives fb_ready each cycle and records accepted writes until the pass ends
    task automatic collect(input bit rnd, input int budget, output int busy_cyc,
                           output int hold_bad, output bit tmo);
        bit stall, seen;
        logic [15:0] pa, pd;
        got_a.delete(); got_d.delete();
        busy_cyc = 0; hold_bad = 0; tmo = 1'b0; stall = 1'b0; seen = 1'b0; pa = '0; pd = '0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(posedge Clk); #1;
            fb_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge Clk);
            if (busy) begin seen = 1'b1; busy_cyc++; end
            if (stall && fb_we && (fb_addr !== pa || fb_data !== pd)) hold_bad++;
            if (fb_we && fb_ready) begin got_a.push_back(fb_addr); got_d.push_back(fb_data); end
            stall = fb_we && !fb_ready; pa = fb_addr; pd = fb_data;
            if (seen && !busy) return;
        end
        tmo = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b0; frame_clk = 1'b0; fb_ready = 1'b0; set_stim(0);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        n_checks++; if (fb_we !== 1'b0)      begin n_fail++; $display("FAIL reset_fb_we: got %b want 0", fb_we); end
        n_checks++; if (fb_addr !== 16'h0)   begin n_fail++; $display("FAIL reset_fb_addr: got %0d want 0", fb_addr); end
        n_checks++; if (fb_data !== 16'h0)   begin n_fail++; $display("FAIL reset_fb_data: got %h want 0000", fb_data); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (overrun !== 1'b0)    begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        frame_clk = 1'b1;
        repeat (6) @(posedge Clk);
        #1 frame_clk = 1'b0;
        @(negedge Clk); Reset = 1'b1;
        repeat (10) @(posedge Clk);
        @(negedge Clk);
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_idle_after_release: busy got %b want 0", busy); end
    endtask

    task automatic test_latency();
        logic b3, b4, w4;
        logic [15:0] a4;
        bit done;
        set_stim(0); fb_ready = 1'b1;
        @(posedge Clk); #1 frame_clk = 1'b1;
        b3 = 1'b0; b4 = 1'b0; w4 = 1'b0; a4 = '0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge Clk); @(negedge Clk);
            if (e == 3) b3 = busy;
            if (e == 4) begin b4 = busy; w4 = fb_we; a4 = fb_addr; end
        end
        frame_clk = 1'b0;
        n_checks++; if (b3 !== 1'b0)         begin n_fail++; $display("FAIL latency_edge3_busy: got %b want 0", b3); end
        n_checks++; if (b4 !== 1'b1)         begin n_fail++; $display("FAIL latency_edge4_busy: got %b want 1", b4); end
        n_checks++; if (w4 !== 1'b1)         begin n_fail++; $display("FAIL latency_first_we: got %b want 1", w4); end
        n_checks++; if (a4 !== 16'd64)       begin n_fail++; $display("FAIL latency_first_addr: got %0d want 64", a4); end
        done = 1'b0;
        for (int i = 0; i < 5000 && !done; i++) begin
            @(negedge Clk);
            if (!busy) done = 1'b1;
        end
        n_checks++; if (!done)               begin n_fail++; $display("FAIL latency_drain: pass still busy after 5000 cycles"); end
    endtask

    task automatic test_main();
        int bc, hb, nbad, first;
        bit tmo;
        set_stim(0); build_expected();
        frame_rise();
        collect(1'b0, 6000, bc, hb, tmo);
        n_checks++; if (tmo)                      begin n_fail++; $display("FAIL main_timeout: pass did not finish in 6000 cycles"); end
        n_checks++; if (got_a.size() != NE_MAIN + 1024) begin n_fail++; $display("FAIL main_count: got %0d writes want %0d", got_a.size(), NE_MAIN + 1024); end
        if (got_a.size() > NE_MAIN) begin
            n_checks++; if (got_a[0] !== 16'd64)        begin n_fail++; $display("FAIL main_first_erase_addr: got %0d want 64", got_a[0]); end
            n_checks++; if (got_d[0] !== 16'h0000)      begin n_fail++; $display("FAIL main_first_erase_data: got %h want 0000", got_d[0]); end
            n_checks++; if (got_d[NE_MAIN-1] !== 16'h0000) begin n_fail++; $display("FAIL main_last_erase_data: got %h want 0000", got_d[NE_MAIN-1]); end
            n_checks++; if (got_a[NE_MAIN] !== 16'd2624) begin n_fail++; $display("FAIL main_first_draw_addr: got %0d want 2624", got_a[NE_MAIN]); end
            n_checks++; if (got_d[NE_MAIN] !== 16'h0F00) begin n_fail++; $display("FAIL main_first_draw_data: got %h want 0F00", got_d[NE_MAIN]); end
        end
        nbad = 0; first = 0;
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++)
            if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin if (nbad == 0) first = i; nbad++; end
        n_checks++; if (nbad != 0) begin n_fail++; $display("FAIL main_sequence: %0d writes differ, first idx %0d got %0d/%h want %0d/%h", nbad, first, got_a[first], got_d[first], exp_a[first], exp_d[first]); end
        n_checks++; if (bc != NE_MAIN + 1024 + 1) begin n_fail++; $display("FAIL main_busy_cycles: got %0d want %0d", bc, NE_MAIN + 1025); end
        n_checks++; if (fb_we !== 1'b0)           begin n_fail++; $display("FAIL main_we_after: got %b want 0", fb_we); end
        ref_a = got_a; ref_d = got_d;
    endtask

    task automatic test_ready_toggle();
        int bc, hb, nbad;
        bit tmo;
        set_stim(0);
        frame_rise();
        collect(1'b1, 20000, bc, hb, tmo);
        fb_ready = 1'b1;
        n_checks++; if (tmo)     begin n_fail++; $display("FAIL toggle_timeout: pass did not finish in 20000 cycles"); end
        n_checks++; if (hb != 0) begin n_fail++; $display("FAIL toggle_hold: %0d stalled writes changed addr/data, want 0", hb); end
        n_checks++; if (got_a.size() != ref_a.size()) begin n_fail++; $display("FAIL toggle_count: got %0d writes want %0d", got_a.size(), ref_a.size()); end
        nbad = 0;
        for (int i = 0; i < got_a.size() && i < ref_a.size(); i++)
            if (got_a[i] !== ref_a[i] || got_d[i] !== ref_d[i]) nbad++;
        n_checks++; if (nbad != 0) begin n_fail++; $display("FAIL toggle_sequence: %0d accepted writes differ from ready=1 run, want 0", nbad); end
    endtask

    task automatic test_offboard();
        int bc, hb, nbad, n12992;
        bit tmo;
        set_stim(1); build_expected();
        frame_rise();
        collect(1'b0, 6000, bc, hb, tmo);
        n_checks++; if (tmo)                 begin n_fail++; $display("FAIL offb_timeout: pass did not finish"); end
        n_checks++; if (got_a.size() != 1792) begin n_fail++; $display("FAIL offb_count: got %0d writes want 1792", got_a.size()); end
        if (got_a.size() > 256) begin
            n_checks++; if (got_a[15] !== 16'd15)  begin n_fail++; $display("FAIL offb_addr15: got %0d want 15", got_a[15]); end
            n_checks++; if (got_a[16] !== 16'd160) begin n_fail++; $display("FAIL offb_addr16: got %0d want 160", got_a[16]); end
            n_checks++; if (got_a[31] !== 16'd175) begin n_fail++; $display("FAIL offb_addr31: got %0d want 175", got_a[31]); end
            n_checks++; if (got_a[255] !== 16'd2415) begin n_fail++; $display("FAIL offb_addr255: got %0d want 2415", got_a[255]); end
        end
        n12992 = 0;
        foreach (got_a[i]) if (got_a[i] == 16'd12992) n12992++;
        n_checks++; if (n12992 != 0) begin n_fail++; $display("FAIL offb_x12_write: got %0d writes at 12992 want 0", n12992); end
        nbad = 0;
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++)
            if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) nbad++;
        n_checks++; if (nbad != 0) begin n_fail++; $display("FAIL offb_sequence: %0d writes differ, want 0", nbad); end
        n_checks++; if (bc != 1793) begin n_fail++; $display("FAIL offb_busy_cycles: got %0d want 1793", bc); end
    endtask

    task automatic test_overrun();
        logic ov1, ov2, pb;
        int rises, gap;
        bit in_gap, gap_done;
        set_stim(0); fb_ready = 1'b1;
        frame_rise();
        ov1 = 1'bx; ov2 = 1'bx; pb = 1'b0; rises = 0; gap = 0; in_gap = 1'b0; gap_done = 1'b0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(posedge Clk); #1;
            frame_clk = (cyc >= 100 && cyc < 104) || (cyc >= 300 && cyc < 304) || (cyc >= 500 && cyc < 504);
            @(negedge Clk);
            if (cyc == 200) ov1 = overrun;
            if (cyc == 400) ov2 = overrun;
            if (busy && !pb) rises++;
            if (!busy && pb && !gap_done) in_gap = 1'b1;
            if (in_gap) begin
                if (busy) begin in_gap = 1'b0; gap_done = 1'b1; end
                else gap++;
            end
            pb = busy;
        end
        frame_clk = 1'b0;
        n_checks++; if (ov1 !== 1'b0)    begin n_fail++; $display("FAIL ovr_after_first: got %b want 0", ov1); end
        n_checks++; if (ov2 !== 1'b1)    begin n_fail++; $display("FAIL ovr_after_second: got %b want 1", ov2); end
        n_checks++; if (rises != 2)      begin n_fail++; $display("FAIL ovr_pass_count: got %0d passes want 2", rises); end
        n_checks++; if (gap != 1)        begin n_fail++; $display("FAIL ovr_restart_gap: got %0d idle cycles want 1", gap); end
        n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL ovr_final_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_draw();
        int nacc, we_hi, busy_hi;
        bit hit;
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL mid_pre_overrun: got %b want 1", overrun); end
        set_stim(0); fb_ready = 1'b1;
        frame_rise();
        nacc = 0; hit = 1'b0;
        for (int cyc = 0; cyc < 4000 && !hit; cyc++) begin
            @(posedge Clk); #1 fb_ready = 1'b1;
            @(negedge Clk);
            if (fb_we && nacc == NE_MAIN + 300) begin
                hit = 1'b1;
                n_checks++; if (fb_addr !== 16'd5516) begin n_fail++; $display("FAIL mid_write300_addr: got %0d want 5516", fb_addr); end
                n_checks++; if (fb_data !== 16'h0F00) begin n_fail++; $display("FAIL mid_write300_data: got %h want 0F00", fb_data); end
                #1 Reset = 1'b0;
                #1;
                n_checks++; if (fb_we !== 1'b0)     begin n_fail++; $display("FAIL mid_we_drop: got %b want 0", fb_we); end
                n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL mid_busy_drop: got %b want 0", busy); end
                n_checks++; if (fb_addr !== 16'h0)  begin n_fail++; $display("FAIL mid_addr_drop: got %0d want 0", fb_addr); end
            end else if (fb_we && fb_ready) begin
                nacc++;
            end
        end
        n_checks++; if (!hit) begin n_fail++; $display("FAIL mid_reached: got %0d accepted writes, never reached %0d", nacc, NE_MAIN + 300); end
        @(posedge Clk); @(negedge Clk);
        Reset = 1'b1;
        we_hi = 0; busy_hi = 0;
        repeat (20) begin
            @(negedge Clk);
            if (fb_we) we_hi++;
            if (busy) busy_hi++;
        end
        n_checks++; if (we_hi != 0)        begin n_fail++; $display("FAIL mid_post_we: got %0d cycles high want 0", we_hi); end
        n_checks++; if (busy_hi != 0)      begin n_fail++; $display("FAIL mid_post_idle: got %0d busy cycles want 0", busy_hi); end
        n_checks++; if (overrun !== 1'b0)  begin n_fail++; $display("FAIL mid_post_overrun: got %b want 0", overrun); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_main();
        test_ready_toggle();
        test_offboard();
        test_overrun();
        test_reset_mid_draw();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
